// File: rtl/mp5_phantom_tracker_pkg.sv
// Shared MP5 sizing and types: upstream packet, phantom map entry and tracker FSM states.
package mp5_phantom_tracker_pkg;
  localparam int NUM_PIPELINES = 2;
  localparam int FIFO_SIZE     = 8;
  localparam int MAP_DEPTH     = 16;
  localparam int ID_W          = 16;
  localparam int PIPE_W        = $clog2(NUM_PIPELINES);
  localparam int ADDR_W        = $clog2(FIFO_SIZE);
  localparam int MAP_IDX_W     = $clog2(MAP_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [PIPE_W-1:0] pipeline;
    logic              is_phantom;
    logic [7:0]        payload;
  } packet_t;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [PIPE_W-1:0] fifo_id;
    logic [ADDR_W-1:0] addr;
  } map_entry_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } tracker_state_t;
endpackage

// File: rtl/mp5_phantom_tracker_id_cam.sv
// Phantom id table: id lookup, duplicate-aware write into the lowest free slot, invalidate, full flag.
module mp5_id_cam
  import mp5_phantom_tracker_pkg::*;
#(
  parameter int DEPTH = MAP_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   i_lookup_id,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_hit_idx,
  output logic [PIPE_W-1:0] o_hit_fifo_id,
  output logic [ADDR_W-1:0] o_hit_addr,
  input  logic              i_wr_en,
  input  logic [ID_W-1:0]   i_wr_id,
  input  logic [PIPE_W-1:0] i_wr_fifo_id,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_inv_en,
  input  logic [IDX_W-1:0]  i_inv_idx,
  output logic              o_full
);
  map_entry_t r_tab [DEPTH];

  logic             w_dup;
  logic [IDX_W-1:0] w_dup_idx;
  logic             w_free;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_wr_idx;

  // Scanning downward leaves the lowest matching / free index in each result.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    w_dup      = 1'b0;
    w_dup_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    o_full     = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_tab[i].valid && (r_tab[i].id == i_lookup_id)) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
      if (r_tab[i].valid && (r_tab[i].id == i_wr_id)) begin
        w_dup     = 1'b1;
        w_dup_idx = IDX_W'(i);
      end
      if (!r_tab[i].valid) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
        o_full     = 1'b0;
      end
    end
  end

  assign o_hit_fifo_id = r_tab[o_hit_idx].fifo_id;
  assign o_hit_addr    = r_tab[o_hit_idx].addr;
  assign w_wr_idx      = w_dup ? w_dup_idx : w_free_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
    end else begin
      if (i_wr_en && (w_dup || w_free)) begin
        r_tab[w_wr_idx].valid   <= 1'b1;
        r_tab[w_wr_idx].id      <= i_wr_id;
        r_tab[w_wr_idx].fifo_id <= i_wr_fifo_id;
        r_tab[w_wr_idx].addr    <= i_wr_addr;
      end
      if (i_inv_en) r_tab[i_inv_idx].valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mp5_phantom_tracker.sv
// Turns upstream packets into stage push/insert commands, remembering phantom slots until the real packet arrives.
// States: S_IDLE | accepting packets ; S_WAIT_ACK | phantom pushed, waiting for the stage's slot report
module mp5_phantom_tracker
  import mp5_phantom_tracker_pkg::*;
#(
  parameter int ACK_TIMEOUT = 3,
  parameter int TMO_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  packet_t           pkt_in,
  input  logic              pkt_in_valid,
  output logic              pkt_in_ready,
  output packet_t           pkt_out,
  output logic [PIPE_W-1:0] fifo_id_out,
  output logic              push_out,
  output logic              insert_out,
  output logic [ADDR_W-1:0] addr_out,
  input  logic              ack_valid_in,
  input  logic [ID_W-1:0]   ack_id_in,
  input  logic [ADDR_W-1:0] ack_addr_in,
  output logic              map_full,
  output logic [15:0]       miss_count,
  output logic [7:0]        timeout_count
);
  tracker_state_t       r_state;
  logic [TMO_W-1:0]     r_tmo;
  logic [PIPE_W-1:0]    r_pend_fifo;
  packet_t              r_pkt;
  logic [PIPE_W-1:0]    r_fifo_id;
  logic                 r_push;
  logic                 r_insert;
  logic [ADDR_W-1:0]    r_addr;
  logic [15:0]          r_miss;
  logic [7:0]           r_timeout;

  logic                 w_accept;
  logic                 w_hit;
  logic [MAP_IDX_W-1:0] w_hit_idx;
  logic [PIPE_W-1:0]    w_hit_fifo_id;
  logic [ADDR_W-1:0]    w_hit_addr;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_inv_en;

  assign pkt_in_ready = !rst && (r_state == S_IDLE) && !(pkt_in.is_phantom && w_full);
  assign w_accept     = pkt_in_valid && pkt_in_ready;
  assign w_wr_en      = (r_state == S_WAIT_ACK) && ack_valid_in;
  assign w_inv_en     = w_accept && !pkt_in.is_phantom && w_hit;

  mp5_id_cam #(.DEPTH(MAP_DEPTH), .IDX_W(MAP_IDX_W)) u_cam (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_id   (pkt_in.id),
    .o_hit         (w_hit),
    .o_hit_idx     (w_hit_idx),
    .o_hit_fifo_id (w_hit_fifo_id),
    .o_hit_addr    (w_hit_addr),
    .i_wr_en       (w_wr_en),
    .i_wr_id       (ack_id_in),
    .i_wr_fifo_id  (r_pend_fifo),
    .i_wr_addr     (ack_addr_in),
    .i_inv_en      (w_inv_en),
    .i_inv_idx     (w_hit_idx),
    .o_full        (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_pend_fifo <= '0;
      r_pkt       <= '0;
      r_fifo_id   <= '0;
      r_push      <= 1'b0;
      r_insert    <= 1'b0;
      r_addr      <= '0;
      r_miss      <= '0;
      r_timeout   <= '0;
    end else begin
      r_pkt     <= '0;
      r_fifo_id <= '0;
      r_push    <= 1'b0;
      r_insert  <= 1'b0;
      r_addr    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pkt <= pkt_in;
            if (pkt_in.is_phantom) begin
              r_push      <= 1'b1;
              r_fifo_id   <= pkt_in.pipeline;
              r_pend_fifo <= pkt_in.pipeline;
              r_tmo       <= TMO_W'(ACK_TIMEOUT - 1);
              r_state     <= S_WAIT_ACK;
            end else if (w_hit) begin
              r_insert  <= 1'b1;
              r_fifo_id <= w_hit_fifo_id;
              r_addr    <= w_hit_addr;
            end else begin
              r_push    <= 1'b1;
              r_fifo_id <= pkt_in.pipeline;
              if (r_miss != 16'hFFFF) r_miss <= r_miss + 16'd1;
            end
          end
        end
        S_WAIT_ACK: begin
          // Terminal count reached means this was the last cycle the ack could land.
          if (ack_valid_in) begin
            r_state <= S_IDLE;
          end else if (r_tmo == '0) begin
            if (r_timeout != 8'hFF) r_timeout <= r_timeout + 8'd1;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pkt_out       = r_pkt;
  assign fifo_id_out   = r_fifo_id;
  assign push_out      = r_push;
  assign insert_out    = r_insert;
  assign addr_out      = r_addr;
  assign map_full      = w_full;
  assign miss_count    = r_miss;
  assign timeout_count = r_timeout;
endmodule

// File: tb/tb_mp5_phantom_tracker.sv
// Bench for mp5_phantom_tracker: directed scenarios plus random traffic against an id-keyed map model.
module tb_mp5_phantom_tracker;
  import mp5_phantom_tracker_pkg::*;

  localparam int ACK_TO = 3;

  logic              clk;
  logic              rst;
  packet_t           pkt_in;
  logic              pkt_in_valid;
  logic              pkt_in_ready;
  packet_t           pkt_out;
  logic [PIPE_W-1:0] fifo_id_out;
  logic              push_out;
  logic              insert_out;
  logic [ADDR_W-1:0] addr_out;
  logic              ack_valid_in;
  logic [ID_W-1:0]   ack_id_in;
  logic [ADDR_W-1:0] ack_addr_in;
  logic              map_full;
  logic [15:0]       miss_count;
  logic [7:0]        timeout_count;

  int n_cmp  = 0;
  int n_fail = 0;

  mp5_phantom_tracker #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_in        (pkt_in),
    .pkt_in_valid  (pkt_in_valid),
    .pkt_in_ready  (pkt_in_ready),
    .pkt_out       (pkt_out),
    .fifo_id_out   (fifo_id_out),
    .push_out      (push_out),
    .insert_out    (insert_out),
    .addr_out      (addr_out),
    .ack_valid_in  (ack_valid_in),
    .ack_id_in     (ack_id_in),
    .ack_addr_in   (ack_addr_in),
    .map_full      (map_full),
    .miss_count    (miss_count),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phantom map keyed by id, table size by entry count.
  typedef struct packed {
    logic [PIPE_W-1:0] f;
    logic [ADDR_W-1:0] a;
  } ment_t;

  ment_t             m_map [logic [15:0]];
  ment_t             m_tmp;
  bit                m_wait;
  int                m_wcnt;
  logic [PIPE_W-1:0] m_pend;
  logic [15:0]       m_miss;
  logic [7:0]        m_tmo;
  bit                m_ready;
  logic              e_push, e_ins;
  packet_t           e_pkt;
  logic [PIPE_W-1:0] e_fifo;
  logic [ADDR_W-1:0] e_addr;

  always @(posedge clk) begin
    m_ready = !rst && !m_wait && !(pkt_in.is_phantom && (m_map.num() == MAP_DEPTH));
    cmp("pkt_in_ready", 64'(pkt_in_ready), 64'(m_ready));
    e_push = 1'b0; e_ins = 1'b0; e_pkt = '0; e_fifo = '0; e_addr = '0;
    if (rst) begin
      m_map.delete();
      m_wait = 1'b0;
      m_miss = '0;
      m_tmo  = '0;
    end else if (m_wait) begin
      if (ack_valid_in) begin
        if (m_map.exists(ack_id_in) || (m_map.num() < MAP_DEPTH)) begin
          m_tmp.f = m_pend;
          m_tmp.a = ack_addr_in;
          m_map[ack_id_in] = m_tmp;
        end
        m_wait = 1'b0;
      end else begin
        m_wcnt++;
        if (m_wcnt == ACK_TO) begin
          if (m_tmo != 8'hFF) m_tmo++;
          m_wait = 1'b0;
        end
      end
    end else if (pkt_in_valid && m_ready) begin
      e_pkt = pkt_in;
      if (pkt_in.is_phantom) begin
        e_push = 1'b1;
        e_fifo = pkt_in.pipeline;
        m_pend = pkt_in.pipeline;
        m_wait = 1'b1;
        m_wcnt = 0;
      end else if (m_map.exists(pkt_in.id)) begin
        e_ins  = 1'b1;
        e_fifo = m_map[pkt_in.id].f;
        e_addr = m_map[pkt_in.id].a;
        m_map.delete(pkt_in.id);
      end else begin
        e_push = 1'b1;
        e_fifo = pkt_in.pipeline;
        if (m_miss != 16'hFFFF) m_miss++;
      end
    end
    #1;
    cmp("push_out", 64'(push_out), 64'(e_push));
    cmp("insert_out", 64'(insert_out), 64'(e_ins));
    cmp("pkt_out", 64'(pkt_out), 64'(e_pkt));
    cmp("fifo_id_out", 64'(fifo_id_out), 64'(e_fifo));
    if (e_ins) cmp("addr_out", 64'(addr_out), 64'(e_addr));
    cmp("map_full", 64'(map_full), 64'(m_map.num() == MAP_DEPTH));
    cmp("miss_count", 64'(miss_count), 64'(m_miss));
    cmp("timeout_count", 64'(timeout_count), 64'(m_tmo));
  end

  task automatic set_in(input bit v, input bit ph, input logic [15:0] id, input logic [PIPE_W-1:0] pipe,
                        input bit av, input logic [15:0] aid, input logic [ADDR_W-1:0] aaddr);
    pkt_in_valid      = v;
    pkt_in.id         = id;
    pkt_in.pipeline   = pipe;
    pkt_in.is_phantom = ph;
    pkt_in.payload    = 8'($urandom);
    ack_valid_in      = av;
    ack_id_in         = aid;
    ack_addr_in       = aaddr;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    set_in(0, 0, 16'h0, '0, 0, 16'h0, '0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    m_wait = 1'b0; m_wcnt = 0; m_pend = '0; m_miss = '0; m_tmo = '0;
    set_in(0, 0, 16'h0, '0, 0, 16'h0, '0);
    step(); step(); step();
    cmp("ready_in_rst", 64'(pkt_in_ready), 64'd0);
    cmp("push_in_rst", 64'(push_out), 64'd0);
    rst = 1'b0;
    #1;
    cmp("ready_after_rst", 64'(pkt_in_ready), 64'd1);
    step();

    // Phantom 0x0005 on pipeline 1, acked with slot 3, then the real packet inserts.
    set_in(1, 1, 16'h0005, 1'b1, 0, 16'h0, '0); step();
    cmp("ph_push", 64'(push_out), 64'd1);
    cmp("ph_fifo", 64'(fifo_id_out), 64'd1);
    cmp("ph_ready_t1", 64'(pkt_in_ready), 64'd0);
    idle();
    cmp("ph_ready_t2", 64'(pkt_in_ready), 64'd0);
    set_in(0, 0, 16'h0, '0, 1, 16'h0005, 3'd3); step();
    cmp("ph_ready_t3", 64'(pkt_in_ready), 64'd1);
    set_in(1, 0, 16'h0005, 1'b0, 0, 16'h0, '0); step();
    cmp("ins_insert", 64'(insert_out), 64'd1);
    cmp("ins_push", 64'(push_out), 64'd0);
    cmp("ins_addr", 64'(addr_out), 64'd3);
    cmp("ins_fifo", 64'(fifo_id_out), 64'd1);
    cmp("ins_full", 64'(map_full), 64'd0);

    // Real packet with no entry is an ordinary push and a miss; misses saturate.
    set_in(1, 0, 16'h00AA, 1'b0, 0, 16'h0, '0); step();
    cmp("miss_push", 64'(push_out), 64'd1);
    cmp("miss_insert", 64'(insert_out), 64'd0);
    cmp("miss_count1", 64'(miss_count), 64'd1);
    repeat (65540) step();
    cmp("miss_sat", 64'(miss_count), 64'hFFFF);
    idle();

    // Fill the table, hold a phantom while full, free entry 0, reuse the slot.
    for (int k = 0; k < MAP_DEPTH; k++) begin
      set_in(1, 1, 16'(16'h0100 + k), PIPE_W'(k), 0, 16'h0, '0); step();
      idle();
      set_in(0, 0, 16'h0, '0, 1, 16'(16'h0100 + k), ADDR_W'(7 - k)); step();
    end
    cmp("full_after_fill", 64'(map_full), 64'd1);
    set_in(1, 1, 16'h0200, 1'b1, 0, 16'h0, '0);
    #1;
    cmp("ready_when_full", 64'(pkt_in_ready), 64'd0);
    step();
    cmp("held_no_push", 64'(push_out), 64'd0);
    set_in(1, 0, 16'h0100, 1'b1, 0, 16'h0, '0); step();
    cmp("free0_insert", 64'(insert_out), 64'd1);
    cmp("free0_addr", 64'(addr_out), 64'd7);
    cmp("free0_fifo", 64'(fifo_id_out), 64'd0);
    cmp("free0_full", 64'(map_full), 64'd0);
    set_in(1, 1, 16'h0200, 1'b1, 0, 16'h0, '0); step();
    idle();
    set_in(0, 0, 16'h0, '0, 1, 16'h0200, 3'd6); step();
    cmp("reuse_full", 64'(map_full), 64'd1);
    set_in(1, 0, 16'h0200, 1'b0, 0, 16'h0, '0); step();
    cmp("reuse_insert", 64'(insert_out), 64'd1);
    cmp("reuse_addr", 64'(addr_out), 64'd6);
    cmp("reuse_fifo", 64'(fifo_id_out), 64'd1);

    // Phantom never acknowledged: three waiting cycles, then timeout.
    set_in(1, 1, 16'h0300, 1'b0, 0, 16'h0, '0); step();
    idle(); idle();
    cmp("tmo_ready_wait", 64'(pkt_in_ready), 64'd0);
    idle();
    cmp("tmo_count", 64'(timeout_count), 64'd1);
    cmp("tmo_ready", 64'(pkt_in_ready), 64'd1);
    cmp("tmo_no_entry", 64'(map_full), 64'd0);

    // Reset in the ack cycle discards the ack and clears the table.
    set_in(1, 1, 16'h0400, 1'b0, 0, 16'h0, '0); step();
    idle();
    rst = 1'b1;
    set_in(0, 0, 16'h0, '0, 1, 16'h0400, 3'd2); step();
    cmp("rst_push", 64'(push_out), 64'd0);
    cmp("rst_pkt", 64'(pkt_out), 64'd0);
    cmp("rst_full", 64'(map_full), 64'd0);
    cmp("rst_tmo", 64'(timeout_count), 64'd0);
    cmp("rst_miss", 64'(miss_count), 64'd0);
    rst = 1'b0;
    idle();
    set_in(1, 0, 16'h0400, 1'b0, 0, 16'h0, '0); step();
    cmp("rst_ack_lost", 64'(insert_out), 64'd0);
    set_in(1, 0, 16'h0101, 1'b1, 0, 16'h0, '0); step();
    cmp("rst_tab_clear", 64'(insert_out), 64'd0);
    cmp("rst_miss2", 64'(miss_count), 64'd2);

    // Random traffic from a small id pool so hits, duplicates, full and timeouts all occur.
    for (int c = 0; c < 3000; c++) begin
      int ack_pct;
      ack_pct = ((c / 500) % 3 == 0) ? 70 : (((c / 500) % 3 == 1) ? 30 : 90);
      rst = ($urandom_range(0, 999) == 0);
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 45,
             16'($urandom_range(0, 23)), PIPE_W'($urandom),
             $urandom_range(0, 99) < ack_pct, 16'($urandom_range(0, 23)), ADDR_W'($urandom));
      step();
    end
    rst = 1'b0;
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mp5_phantom_tracker.md
# mp5_phantom_tracker

Ingress-side companion to the MP5 per-stage FIFO block. Receives packets from the upstream parser and turns each into a push or insert command for the downstream stage. On a push it records the FIFO slot address the stage reports back for each phantom packet. When the matching real packet later arrives, it issues an insert that overwrites the phantom in place, preserving the phantom's reserved position in the stage FIFO.

## Interface
Parameters:
- NUM_PIPELINES, 2, number of pipelines / stage FIFOs; power of two.
- FIFO_SIZE, 8, depth of each stage FIFO; addresses are $clog2(FIFO_SIZE) bits.
- MAP_DEPTH, 16, number of outstanding phantom entries tracked.
- ACK_TIMEOUT, 3, cycles to wait for the stage's address report before giving up.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pkt_in  in  Packet  packet from upstream; fields used: id, pipeline, is_phantom.
- pkt_in_valid  in  1  pkt_in is valid.
- pkt_in_ready  out  1  tracker accepts pkt_in this cycle.
- pkt_out  out  Packet  packet to stage, registered copy of accepted pkt_in.
- fifo_id_out  out  $clog2(NUM_PIPELINES)  target stage FIFO = accepted pkt_in.pipeline.
- push_out  out  1  one-cycle push command to stage.
- insert_out  out  1  one-cycle insert command to stage.
- addr_out  out  $clog2(FIFO_SIZE)  slot address for insert.
- ack_valid_in  in  1  stage reports a phantom's slot this cycle.
- ack_id_in  in  16  phantom id reported by stage.
- ack_addr_in  in  $clog2(FIFO_SIZE)  slot address reported by stage.
- map_full  out  1  all MAP_DEPTH entries valid.
- miss_count  out  16  real packets with no map entry; saturating.
- timeout_count  out  8  phantom pushes never acknowledged; saturating.

## Operation
- Map table: MAP_DEPTH entries of {valid, id[15:0], fifo_id, addr}. All entries are invalid after reset.
- FSM states: IDLE, WAIT_ACK.
- **IDLE**
  - pkt_in_ready = !(pkt_in.is_phantom && map_full).
  - Phantom accepted: push_out=1 next cycle with pkt_out/fifo_id_out; FSM goes to WAIT_ACK; wait counter cleared.
  - Real packet accepted, id matches a valid entry (combinational compare in the accept cycle): insert_out=1 next cycle, addr_out = entry.addr, fifo_id_out = entry.fifo_id. The entry is invalidated at the same edge. FSM stays in IDLE.
  - Real packet accepted, no match: push_out=1 as an ordinary push; miss_count++.
- **WAIT_ACK**
  - pkt_in_ready=0.
  - On ack_valid_in: write {1, ack_id_in, latched fifo_id, ack_addr_in} into the lowest-index invalid entry, then go to IDLE.
  - If no ack after ACK_TIMEOUT cycles in WAIT_ACK: timeout_count++, go to IDLE, no entry written.
- Duplicate ack id already valid in the table: the existing entry is overwritten; no new entry is allocated.
- ack_valid_in in IDLE is ignored.
- push_out and insert_out are never both 1.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: pkt_in_ready=0 during rst, 1 in the first cycle after; pkt_out=0, fifo_id_out=0, push_out=0, insert_out=0, addr_out=0; map_full=0; miss_count=0; timeout_count=0; FSM=IDLE.
- Packet accepted at cycle T (pkt_in_valid && pkt_in_ready): pkt_out, fifo_id_out and push_out/insert_out are valid in T+1 for exactly one cycle, then return to 0.
- The stage registers its address report at the end of T+1, so ack_valid_in nominally arrives in T+2. The entry is visible to lookups from T+3. pkt_in_ready returns high in T+3.
- Throughput: one real packet per cycle; one phantom per 3 cycles nominal.
- map_full is registered and reflects the table state after the previous edge.
- rst asserted mid-WAIT_ACK: the pending ack is discarded, all entries are cleared, no counter changes.

## Structure
- Packet, NUM_PIPELINES and FIFO_SIZE come from the shared mp5 package. Add MAP_DEPTH and the map entry struct there too.
- One natural sub-module: mp5_id_cam, the MAP_DEPTH-entry table. It provides a match/hit/index port, a lowest-free-slot priority encoder, write and invalidate ports, and a full flag.
- The FSM and counters live in the top.

## Test plan
- Reset then phantom id=0x0005, pipeline=1 at T -> push_out=1, fifo_id_out=1 at T+1; ready=0 in T+1..T+2. Ack (0x0005, addr=3) at T+2 -> entry written, ready=1 at T+3.
- Following real packet id=0x0005 -> insert_out=1, addr_out=3, fifo_id_out=1 one cycle after accept; entry freed, map_full=0.
- Real packet id=0x00AA with empty table -> push_out=1, insert_out=0, miss_count=1. Repeat 70000 times -> miss_count stays 0xFFFF.
- Fill 16 phantoms with acks -> map_full=1. A 17th phantom is held (ready=0) while a real packet matching entry 0 is accepted. The freed slot is reused for the next phantom.
- Phantom with no ack -> after 3 WAIT_ACK cycles, timeout_count=1, FSM in IDLE, no entry added.
- rst asserted in the cycle an ack arrives -> table empty, all outputs 0, ack not recorded.
